// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the MIPS write-back path:
//                destination-select codes, result-source indices and the
//                default link register.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Destination register select
  typedef enum logic [1:0] {
    REGDST_RT   = 2'b00,
    REGDST_RD   = 2'b01,
    REGDST_LINK = 2'b10,
    REGDST_NONE = 2'b11
  } regdst_e;

  // Result source indices into the packed source bus
  localparam int SRC_ALU  = 0;
  localparam int SRC_DM   = 1;
  localparam int SRC_PC8  = 2;
  localparam int SRC_HILO = 3;

  // $ra, written by jal/jalr/bgezal-style instructions
  localparam int LINK_REG_DEF = 31;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_skid_buf
//  Description : Two-entry FIFO of resolved write-back entries {we,addr,data}
//                with valid/ready on both sides and a synchronous flush.
//                Head outputs are driven from storage only and read as zero
//                while the buffer is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [REG_AW-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [REG_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = 1 + REG_AW + DATA_W;

  logic [ENTRY_W-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  // Handshake: a full buffer still accepts when the head leaves this cycle
  always_comb begin
    in_ready  = (r_count != 2'd2) | out_ready;
    out_valid = (r_count != 2'd0);
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
    w_head    = out_valid ? r_mem[r_rd_ptr] : '0;
    {out_we, out_addr, out_data} = w_head;
    occupancy = r_count;
  end

  // Pointer and count update; flush empties the buffer and drops any push
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care once the count says empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_we, in_addr, in_data};
  end

endmodule : wb_skid_buf
`default_nettype wire

// File: rtl/wb_sel_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sel_stage
//  Description : MEM->WB boundary stage. Resolves result source, destination
//                register and write enable on accept, then holds the result
//                in a two-entry skid buffer toward the register file.
//                Optional macro WB_SEL_ZERO_SUPPRESS_EN: when defined, entries
//                whose destination resolves to $0 are stored with we = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_sel_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NSRC     = 4,
  parameter int SEL_W    = 2,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       data_sel,
  input  logic [REG_AW-1:0]      rt,
  input  logic [REG_AW-1:0]      rd,
  input  logic [1:0]             regdst,
  input  logic                   reg_we,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   wb_we,
  output logic [REG_AW-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [1:0]             occupancy
);

  logic [DATA_W-1:0] w_src [NSRC];
  logic [DATA_W-1:0] w_data;
  logic [REG_AW-1:0] w_addr;
  logic              w_we;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_src[gi] = src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Source mux; an index with no matching source yields zero
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (data_sel == SEL_W'(i)) w_data = w_src[i];
    end
  end

  // Destination and effective write enable
  always_comb begin
    w_addr = '0;
    case (regdst)
      REGDST_RT:   w_addr = rt;
      REGDST_RD:   w_addr = rd;
      REGDST_LINK: w_addr = REG_AW'(LINK_REG);
      default:     w_addr = '0;
    endcase
    w_we = reg_we & (regdst != REGDST_NONE);
`ifdef WB_SEL_ZERO_SUPPRESS_EN
    w_we = w_we & (w_addr != '0);
`else
    w_we = w_we;
`endif
  end

  wb_skid_buf #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_we     (w_we),
    .in_addr   (w_addr),
    .in_data   (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_we    (wb_we),
    .out_addr  (wb_addr),
    .out_data  (wb_data),
    .occupancy (occupancy)
  );

endmodule : wb_sel_stage
`default_nettype wire
